clk_rate_ctrl: RTL and testbench
================================

// Module: clk_rate_ctrl
// PURPOSE
//  Parametrised CPU clock generator for the FPGA top level. Divides board clk into the
//  slow CPU clock clk_N from one of 2**SEL_W selectable half-period divisors. Adds
//  run/pause/single-step modes, glitch-free rate and mode changes, a 1-cycle tick
//  strobe and a tick counter for the 7-seg display mux.
// PARAMETERS
//  SEL_W   2         width of rate_sel; 2**SEL_W divisor slots
//  CNT_W   32        width of half-period counter and divisors
//  DIV0    10000     half-period in clk cycles, rate_sel=0 (clk_N toggles every DIVk cycles)
//  DIV1    100000    rate_sel=1
//  DIV2    1000000   rate_sel=2
//  DIV3    10000000  rate_sel=3; slots above 3 (SEL_W>2) reuse DIV3
//  TCNT_W  32        width of tick_count
// PORTS
//  clk         in   1       board clock; all logic on posedge
//  clr         in   1       synchronous reset, active-high
//  rate_sel    in   SEL_W   divisor select; sampled only at toggle boundaries
//  mode        in   2       00 run, 01 pause, 10 single-step, 11 treated as pause
//  step        in   1       step request (level, debounced externally); rising edge used
//  clk_N       out  1       divided CPU clock, registered
//  tick        out  1       1-cycle pulse, high in the cycle clk_N becomes 1
//  tick_count  out  TCNT_W  number of clk_N rising edges since reset, wraps
//  running     out  1       1 when FSM is in RUN
// BEHAVIOUR
//  - Reset (clr=1 at posedge): clk_N=0, tick=0, tick_count=0, cnt=0, step_q=0,
//    state=RUN, running=1, div_q<=DIV[rate_sel]. Reset wins over every other event.
//  - Divisor values 0 are treated as 1 (toggle every cycle).
//  - FSM states: RUN, DRAIN, PAUSE, STEP_IDLE, STEP_HI, STEP_LO.
//  - RUN: cnt++ each cycle; at cnt==div_q-1: cnt<=0, clk_N<=~clk_N,
//    div_q<=DIV[rate_sel]. A rate change never shortens or stretches the running phase.
//  - Leaving RUN (mode!=00): if clk_N=0, go directly to PAUSE/STEP_IDLE on the next
//    cycle, cnt<=0. If clk_N=1, go to DRAIN: keep counting until the high phase
//    completes (clk_N falls), then enter target state per mode at that moment.
//    clk_N is always parked low; no runt high pulse.
//  - PAUSE: cnt, clk_N, div_q hold. mode=00 -> RUN with cnt=0, div_q<=DIV[rate_sel];
//    mode=10 -> STEP_IDLE.
//  - STEP_IDLE: step edge = step & ~step_q (step_q registered each cycle, also in reset).
//    On edge: clk_N<=1, tick=1, cnt<=0, div_q<=DIV[rate_sel] -> STEP_HI.
//  - STEP_HI: clk_N high for div_q cycles total, then clk_N<=0 -> STEP_LO.
//    STEP_LO: low for div_q cycles, then -> STEP_IDLE. Step edges in STEP_HI/LO ignored.
//  - Mode changes during STEP_HI/STEP_LO take effect only on return to STEP_IDLE;
//    mode=00 from STEP_IDLE/PAUSE -> RUN, mode 01/11 -> PAUSE.
//  - tick: registered, high exactly in the cycle clk_N first reads 1; tick_count
//    increments in that same cycle, wraps 2**TCNT_W-1 -> 0.
//  - Latency: after clr release in RUN, first clk_N rise after div_q cycles.
// TESTING (bench uses DIV0=2, DIV1=3, DIV2=5, DIV3=0)
//  1 clr 3 cycles, rate_sel=0, mode=00 -> clk_N period 4 clk, 50% duty;
//    tick every 4 clk; tick_count=5 after 5th rise.
//  2 Run rate_sel=1, switch to 2 mid-high-phase -> current phase stays 3 cycles,
//    following phases 5 cycles; no phase of length 4 or other.
//  3 mode=01 while clk_N=1 with 1 cycle into phase -> clk_N stays high 2 more
//    cycles, falls, then holds 0 indefinitely; running=0; tick_count frozen.
//  4 mode=10, rate_sel=2, one step rising edge -> clk_N high 5 cycles, low 5,
//    exactly one tick, tick_count+1; second step edge during HI ignored.
//  5 rate_sel=3 (DIV3=0) in RUN -> clk_N toggles every clk; tick every 2 clk.
//  6 clr asserted in STEP_HI -> next cycle clk_N=0, tick_count=0, running=1;
//    force tick_count to 2**TCNT_W-1, one rise -> wraps to 0.

Source files
------------

// File: rtl/clk_rate_ctrl.sv
// CPU clock generator: divides the board clock into clk_N using one of
// 2**SEL_W half-period divisors. Supports run, pause and single-step modes
// with glitch-free rate/mode changes, a rise strobe and a rise counter.
module clk_rate_ctrl #(
  parameter int unsigned      SEL_W  = 2,
  parameter int unsigned      CNT_W  = 32,
  parameter logic [CNT_W-1:0] DIV0   = CNT_W'(10000),
  parameter logic [CNT_W-1:0] DIV1   = CNT_W'(100000),
  parameter logic [CNT_W-1:0] DIV2   = CNT_W'(1000000),
  parameter logic [CNT_W-1:0] DIV3   = CNT_W'(10000000),
  parameter int unsigned      TCNT_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [SEL_W-1:0]  rate_sel,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic              clk_N,
  output logic              tick,
  output logic [TCNT_W-1:0] tick_count,
  output logic              running
);

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_PAUSE,
    S_STEP_IDLE,
    S_STEP_HI,
    S_STEP_LO
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    div_q, div_d;
  logic                clk_n_q, clk_n_d;
  logic                tick_q, tick_d;
  logic [TCNT_W-1:0]   tick_count_q, tick_count_d;
  logic                step_q, step_d;

  logic [CNT_W-1:0]    rate_div;
  logic                last;
  logic                step_edge;
  state_t              target;

  // Divisor lookup; slots above 3 reuse DIV3, a zero divisor acts as 1.
  function automatic logic [CNT_W-1:0] div_of(input logic [SEL_W-1:0] sel);
    logic [CNT_W-1:0] d;
    int unsigned      s;
    s = 32'(sel);
    if (s == 0)      d = DIV0;
    else if (s == 1) d = DIV1;
    else if (s == 2) d = DIV2;
    else             d = DIV3;
    if (d == '0) d = CNT_W'(1);
    return d;
  endfunction

  // Shared decode: selected divisor, end of phase, step edge, mode target.
  always_comb begin
    rate_div  = div_of(rate_sel);
    last      = (cnt_q == div_q - CNT_W'(1));
    step_edge = step & ~step_q;
    case (mode)
      2'b00:   target = S_RUN;
      2'b10:   target = S_STEP_IDLE;
      default: target = S_PAUSE;
    endcase
  end

  // Next-state, counter and clk_N logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    clk_n_d = clk_n_q;
    step_d  = step;
    case (state_q)
      S_RUN: begin
        if (mode != 2'b00) begin
          // A high phase is always completed before parking low; if the
          // current cycle already ends it, fall and leave without DRAIN.
          if (!clk_n_q) begin
            state_d = target;
            cnt_d   = '0;
          end else if (last) begin
            clk_n_d = 1'b0;
            cnt_d   = '0;
            div_d   = rate_div;
            state_d = target;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_DRAIN;
          end
        end else if (last) begin
          cnt_d   = '0;
          clk_n_d = ~clk_n_q;
          div_d   = rate_div;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (last) begin
          clk_n_d = 1'b0;
          cnt_d   = '0;
          div_d   = rate_div;
          state_d = target;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAUSE: begin
        if (mode == 2'b00) begin
          state_d = S_RUN;
          cnt_d   = '0;
          div_d   = rate_div;
        end else if (mode == 2'b10) begin
          state_d = S_STEP_IDLE;
        end
      end
      S_STEP_IDLE: begin
        if (mode == 2'b00) begin
          state_d = S_RUN;
          cnt_d   = '0;
          div_d   = rate_div;
        end else if (mode != 2'b10) begin
          state_d = S_PAUSE;
        end else if (step_edge) begin
          clk_n_d = 1'b1;
          cnt_d   = '0;
          div_d   = rate_div;
          state_d = S_STEP_HI;
        end
      end
      S_STEP_HI: begin
        if (last) begin
          clk_n_d = 1'b0;
          cnt_d   = '0;
          state_d = S_STEP_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STEP_LO: begin
        if (last) begin
          cnt_d   = '0;
          state_d = S_STEP_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Rise strobe and rise counter track the registered clk_N transition.
  always_comb begin
    tick_d       = clk_n_d & ~clk_n_q;
    tick_count_d = tick_count_q;
    if (tick_d) tick_count_d = tick_count_q + TCNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      div_q        <= rate_div;
      clk_n_q      <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      clk_n_q      <= clk_n_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      step_q       <= step_d;
    end
  end

  assign clk_N      = clk_n_q;
  assign tick       = tick_q;
  assign tick_count = tick_count_q;
  assign running    = (state_q == S_RUN);

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Directed bench for clk_rate_ctrl with small divisors (2, 3, 5, 0).
module tb_clk_rate_ctrl;

  logic        clk;
  logic        clr;
  logic [1:0]  rate_sel;
  logic [1:0]  mode;
  logic        step;
  logic        clk_N;
  logic        tick;
  logic [31:0] tick_count;
  logic        running;

  logic        clk_N_s;
  logic        tick_s;
  logic [2:0]  tick_count_s;
  logic        running_s;

  int          n_cmp;
  int          n_bad;
  logic        exp_prev;
  logic [31:0] exp_tc;

  clk_rate_ctrl #(
    .SEL_W(2), .CNT_W(32),
    .DIV0(32'd2), .DIV1(32'd3), .DIV2(32'd5), .DIV3(32'd0),
    .TCNT_W(32)
  ) dut (
    .clk(clk), .clr(clr), .rate_sel(rate_sel), .mode(mode), .step(step),
    .clk_N(clk_N), .tick(tick), .tick_count(tick_count), .running(running)
  );

  // Narrow tick counter instance used to observe the counter wrap.
  clk_rate_ctrl #(
    .SEL_W(2), .CNT_W(32),
    .DIV0(32'd2), .DIV1(32'd3), .DIV2(32'd5), .DIV3(32'd0),
    .TCNT_W(3)
  ) dut_s (
    .clk(clk), .clr(clr), .rate_sel(rate_sel), .mode(mode), .step(step),
    .clk_N(clk_N_s), .tick(tick_s), .tick_count(tick_count_s), .running(running_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; pat holds expected clk_N per cycle, oldest bit first.
  task automatic chk_clk(input string tag, input int n, input logic [63:0] pat);
    for (int i = n - 1; i >= 0; i--) begin
      logic e_clk;
      logic e_tick;
      tick_edge();
      e_clk  = pat[i];
      e_tick = e_clk & ~exp_prev;
      if (e_tick) exp_tc = exp_tc + 32'd1;
      exp_prev = e_clk;
      check({tag, "_clk"},  {63'd0, clk_N}, {63'd0, e_clk});
      check({tag, "_tick"}, {63'd0, tick},  {63'd0, e_tick});
      check({tag, "_tcnt"}, {32'd0, tick_count}, {32'd0, exp_tc});
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    exp_prev = 1'b0;
    exp_tc   = '0;
    clr      = 1'b1;
    rate_sel = 2'd0;
    mode     = 2'b00;
    step     = 1'b0;

    // 1: reset, then rate 0 (half-period 2)
    repeat (3) tick_edge();
    check("rst_clk",  {63'd0, clk_N}, 64'd0);
    check("rst_tick", {63'd0, tick},  64'd0);
    check("rst_tcnt", {32'd0, tick_count}, 64'd0);
    check("rst_run",  {63'd0, running}, 64'd1);
    clr = 1'b0;
    chk_clk("t1", 18, 64'b011001100110011001);
    check("t1_five", {32'd0, tick_count}, 64'd5);

    // 2: rate 1, then switch to rate 2 one cycle into a high phase
    rate_sel = 2'd1;
    chk_clk("t2a", 6, 64'b100011);
    rate_sel = 2'd2;
    chk_clk("t2b", 17, 64'b10000011111000001);

    // 3: pause requested one cycle into a 3-cycle high phase
    rate_sel = 2'd1;
    chk_clk("t3a", 8, 64'b11110001);
    check("t3_run_before", {63'd0, running}, 64'd1);
    mode = 2'b01;
    chk_clk("t3b", 1, 64'b1);
    check("t3_run_drain", {63'd0, running}, 64'd0);
    chk_clk("t3c", 11, 64'b10000000000);
    check("t3_frozen", {32'd0, tick_count}, 64'd9);

    // 4: single step at rate 2, second step edge during high ignored
    mode     = 2'b10;
    rate_sel = 2'd2;
    chk_clk("t4a", 2, 64'b00);
    check("t4_run", {63'd0, running}, 64'd0);
    step = 1'b1;
    chk_clk("t4b", 2, 64'b11);
    step = 1'b0;
    chk_clk("t4c", 1, 64'b1);
    step = 1'b1;
    chk_clk("t4d", 14, 64'b11000000000000);
    check("t4_one_tick", {32'd0, tick_count}, 64'd10);

    // 5: zero divisor slot toggles every cycle
    mode     = 2'b00;
    rate_sel = 2'd3;
    chk_clk("t5", 10, 64'b0101010101);
    check("t5_run", {63'd0, running}, 64'd1);
    check("t5_tcnt", {32'd0, tick_count}, 64'd15);

    // 6: reset during STEP_HI, then counter wrap on the 3-bit instance
    mode = 2'b10;
    step = 1'b0;
    chk_clk("t6a", 1, 64'b0);
    rate_sel = 2'd2;
    step     = 1'b1;
    chk_clk("t6b", 2, 64'b11);
    check("t6_run_step", {63'd0, running}, 64'd0);
    clr      = 1'b1;
    rate_sel = 2'd3;
    tick_edge();
    check("t6_rst_clk",  {63'd0, clk_N}, 64'd0);
    check("t6_rst_tick", {63'd0, tick},  64'd0);
    check("t6_rst_tcnt", {32'd0, tick_count}, 64'd0);
    check("t6_rst_run",  {63'd0, running}, 64'd1);
    check("t6_rst_tcs",  {61'd0, tick_count_s}, 64'd0);
    clr      = 1'b0;
    mode     = 2'b00;
    step     = 1'b0;
    exp_prev = 1'b0;
    exp_tc   = '0;
    chk_clk("t6c", 13, 64'b1010101010101);
    check("t6_tcs_max",  {61'd0, tick_count_s}, 64'd7);
    chk_clk("t6d", 2, 64'b01);
    check("t6_tcs_wrap", {61'd0, tick_count_s}, 64'd0);
    check("t6_tcnt8",    {32'd0, tick_count}, 64'd8);

    // 7: mode 11 parks like pause
    mode = 2'b11;
    chk_clk("t7", 4, 64'b0000);
    check("t7_run", {63'd0, running}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
